// File: rtl/qpsk_symbol_demapper.sv
// QPSK hard-decision demapper: slices recovered symbols to dibits and uses the timing error to
// decide lock. While locked it packs dibits MSB-first into bytes and queues them in a 4-entry FIFO.
module qpsk_symbol_demapper #(
    parameter int unsigned LOCK_THR   = 4096,
    parameter int unsigned LOCK_CNT   = 32,
    parameter int unsigned UNLOCK_CNT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sym_valid,
    input  logic signed [15:0] sym_i,
    input  logic signed [15:0] sym_q,
    input  logic signed [15:0] m_in,
    output logic        [7:0]  byte_data,
    output logic               byte_valid,
    input  logic               byte_ready,
    output logic               locked,
    output logic               overflow
);

    localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);
    localparam int unsigned BadW  = $clog2(UNLOCK_CNT + 1);

    typedef enum logic {StSearch, StLocked} state_e;

    state_e           state_q;
    logic [GoodW-1:0] good_q;
    logic [BadW-1:0]  bad_q;
    logic [1:0]       pack_cnt_q;
    logic [5:0]       pack_buf_q;
    logic [7:0]       mem_q [4];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [2:0]       count_q;
    logic             locked_q;
    logic             overflow_q;

    logic [15:0] m_abs;
    logic        sym_good;
    logic [1:0]  dibit;
    logic        pack_en;
    logic        unlocking;
    logic        push;
    logic [7:0]  push_byte;
    logic        pop;
    logic        full;
    logic        push_ok;

    always_comb begin
        // -32768 has no positive twin in 16 bits, so it saturates.
        m_abs = 16'h7fff;
        if (m_in != -16'sd32768) begin
            m_abs = m_in[15] ? (~m_in + 16'd1) : m_in;
        end
        sym_good  = ({16'd0, m_abs} <= LOCK_THR);
        dibit     = {sym_i < 16'sd0, sym_q < 16'sd0};
        pack_en   = sym_valid && (state_q == StLocked);
        unlocking = pack_en && !sym_good && (bad_q == BadW'(UNLOCK_CNT - 1));
        push      = pack_en && (pack_cnt_q == 2'd3);
        push_byte = {pack_buf_q, dibit};
        full      = (count_q == 3'd4);
        pop       = (count_q != 3'd0) && byte_ready;
        push_ok   = push && (!full || pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StSearch;
            good_q     <= '0;
            bad_q      <= '0;
            pack_cnt_q <= '0;
            pack_buf_q <= '0;
            for (int k = 0; k < 4; k++) mem_q[k] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            locked_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (sym_valid) begin
                unique case (state_q)
                    StSearch: begin
                        if (!sym_good) begin
                            good_q <= '0;
                        end else if (good_q == GoodW'(LOCK_CNT - 1)) begin
                            state_q  <= StLocked;
                            locked_q <= 1'b1;
                            good_q   <= '0;
                            bad_q    <= '0;
                        end else begin
                            good_q <= good_q + 1'b1;
                        end
                    end
                    StLocked: begin
                        if (sym_good) begin
                            bad_q <= '0;
                        end else if (unlocking) begin
                            state_q  <= StSearch;
                            locked_q <= 1'b0;
                            good_q   <= '0;
                            bad_q    <= '0;
                        end else begin
                            bad_q <= bad_q + 1'b1;
                        end
                    end
                    default: state_q <= StSearch;
                endcase
            end

            // The unlocking symbol may still complete a byte (push), but any partial is dropped.
            if (unlocking) begin
                pack_cnt_q <= '0;
                pack_buf_q <= '0;
            end else if (pack_en) begin
                pack_cnt_q <= pack_cnt_q + 1'b1;
                pack_buf_q <= push_byte[5:0];
            end

            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_byte;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop) begin
                count_q <= count_q - 1'b1;
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign byte_valid = (count_q != 3'd0);
    assign byte_data  = byte_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign locked     = locked_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/qpsk_symbol_demapper.md
QPSK_SYMBOL_DEMAPPER -- requirements
Module: qpsk_symbol_demapper

Interface
REQ-001 SHALL have parameter LOCK_THR, default 4096, maximum |m_in| for a symbol to count as good.
REQ-002 SHALL have parameter LOCK_CNT, default 32, consecutive good symbols needed to declare lock.
REQ-003 SHALL have parameter UNLOCK_CNT, default 8, consecutive bad symbols needed to drop lock.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sym_valid  input  1  one-cycle strobe marking a recovered symbol from the timing-recovery stage.
REQ-007 SHALL have port sym_i  input  16  signed recovered in-phase symbol (timing-recovery I_out).
REQ-008 SHALL have port sym_q  input  16  signed recovered quadrature symbol (timing-recovery Q_out).
REQ-009 SHALL have port m_in  input  16  signed Gardner timing error for the same symbol (timing-recovery m_k).
REQ-010 SHALL have port byte_data  output  8  head of output FIFO.
REQ-011 SHALL have port byte_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port byte_ready  input  1  downstream accepts byte_data this cycle.
REQ-013 SHALL have port locked  output  1  high while FSM in LOCKED.
REQ-014 SHALL have port overflow  output  1  sticky flag, a completed byte was dropped.

Function
REQ-015 SHALL ignore sym_i, sym_q and m_in on cycles where sym_valid=0.
REQ-016 SHALL slice each valid symbol to dibit {bI,bQ}: bI=1 iff sym_i<0, bQ=1 iff sym_q<0; zero slices to 0.
REQ-017 SHALL compute |m_in| with -32768 saturated to 32767; symbol good iff |m_in| <= LOCK_THR, else bad.
REQ-018 SHALL implement FSM states SEARCH (reset state) and LOCKED; locked is registered, equal to (state==LOCKED).
REQ-019 In SEARCH SHALL increment good counter on good symbol, clear it on bad; on the LOCK_CNT-th consecutive good symbol SHALL enter LOCKED next cycle and clear both counters.
REQ-020 In LOCKED SHALL increment bad counter on bad symbol, clear it on good; on the UNLOCK_CNT-th consecutive bad symbol SHALL enter SEARCH next cycle and clear both counters.
REQ-021 SHALL pack dibits only for symbols arriving while state==LOCKED; the symbol causing SEARCH->LOCKED is not packed, the symbol causing LOCKED->SEARCH is packed.
REQ-022 SHALL pack MSB-first: 1st dibit to [7:6], 2nd [5:4], 3rd [3:2], 4th [1:0]; 4th dibit completes a byte, pushed to FIFO same cycle.
REQ-023 SHALL discard a partial byte and clear the pack counter on LOCKED->SEARCH.
REQ-024 SHALL buffer bytes in a 4-entry FIFO, first-in first-out; pop when byte_valid & byte_ready.
REQ-025 A byte completed on cycle n SHALL appear on byte_data with byte_valid=1 at cycle n+1 when FIFO was empty.
REQ-026 Push to full FIFO without simultaneous pop SHALL drop the new byte, keep contents, set overflow (held until reset).
REQ-027 Simultaneous push and pop on full FIFO SHALL perform both; no overflow.
REQ-028 byte_data SHALL be 0 when FIFO empty.

Reset
REQ-029 While reset=0 at a clock edge SHALL set state=SEARCH, all counters 0, FIFO empty, pack buffer 0; locked=0, byte_valid=0, byte_data=0, overflow=0 next cycle.
REQ-030 Reset mid-operation SHALL discard all FIFO contents and partial bytes regardless of byte_ready.

Verification
REQ-031 Reset: hold reset=0 two cycles with sym_valid toggling -> locked=0, byte_valid=0, byte_data=0, overflow=0.
REQ-032 Lock: 31 good symbols (m_in=100), 1 bad (m_in=5000), then 32 good -> locked stays 0 through first 32, rises cycle after 64th symbol.
REQ-033 Packing: locked, byte_ready=1, symbols (20000,22000),(-20000,22000),(20000,-22000),(-20000,-22000) -> byte_data=0x27, byte_valid=1 for one cycle after 4th.
REQ-034 Overflow: locked, byte_ready=0, 20 symbols all (20000,22000) except first (-20000,-22000) -> first byte 0xC0, FIFO holds 4 bytes, overflow=1; byte_ready=1 drains 0xC0,0x00,0x00,0x00 then byte_valid=0, overflow stays 1.
REQ-035 Unlock: locked, 2 packed symbols then 8 symbols m_in=-32768 -> locked falls cycle after 8th bad; no byte emitted from partial data; next lock restarts at [7:6].
REQ-036 Simultaneous: FIFO full, byte_ready=1 on cycle a byte completes -> no overflow, FIFO count stays 4, order preserved.
